pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised, elastic successor to the fetch/decode boundary register.
- Carries NFIELDS packed fields of DATA_W bits each, for example PC+1, instruction, immediate and input port.
- Uses a valid/ready handshake with a 2-entry skid buffer, so back-pressure is fully registered and throughput stays at one word per cycle.
- Adds flush (bubble insertion) and a sticky interrupt capture that never drops a request while the stage is stalled.
- Placed between any two pipeline stages; the first instance sits at IF/ID.

Parameters:
DATA_W, 8, width of one field in bits
NFIELDS, 4, number of fields in the payload
NOP_VAL, 8'h00, value forced into field 0 (the instruction slot) when a bubble is presented

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset, asynchronous and active-high
in_valid  input  1  upstream word present
in_ready  output  1  stage can accept; registered, depends only on occupancy
in_data  input  NFIELDS*DATA_W  upstream payload; field k is at bits [k*DATA_W +: DATA_W]
in_irq  input  1  interrupt request; single-cycle pulse or level
flush  input  1  discard all held words (branch taken / redirect)
out_valid  output  1  main entry holds a valid word
out_ready  input  1  downstream accepts
out_data  output  NFIELDS*DATA_W  payload of the main entry
out_irq  output  1  interrupt flag attached to the main entry

Behaviour:
- Storage: main entry (drives outputs) and skid entry. Each entry holds data, irq flag and valid. Occupancy cnt is 0, 1 or 2.
- Reset, asynchronous:
  - cnt=0, in_ready=1, out_valid=0, out_irq=0, irq_pend=0.
  - out_data=0, except field 0 = NOP_VAL.
  - Skid contents cleared.
- Handshakes: acc = in_valid & in_ready; pop = out_valid & out_ready. in_ready = (cnt != 2), derived from registered cnt only, with no combinational path from out_ready.
- Transitions when flush=0:
  - cnt 0, acc: word goes to main, cnt becomes 1. Latency is 1 cycle from in_* to out_*.
  - cnt 1, acc & pop: main loads the new word, cnt stays 1.
  - cnt 1, acc & !pop: word goes to skid, cnt becomes 2, in_ready falls the next cycle.
  - cnt 1, pop & !acc: cnt becomes 0, out_valid falls.
  - cnt 2, pop: skid moves to main, cnt becomes 1, in_ready rises. acc cannot occur because in_ready=0.
  - cnt 2, !pop: all state holds. This is the stall case and the outputs are stable.
- Ordering: strict FIFO, no reordering, no duplication.
- Interrupt capture:
  - The irq flag stored with an accepted word is in_irq | irq_pend. irq_pend clears on that accept.
  - in_irq=1 without acc sets irq_pend.
  - irq_pend is sticky until attached to a word.
- Flush, synchronous, highest priority:
  - Next cycle: cnt=0, out_valid=0, out_irq=0, field 0 of out_data = NOP_VAL, other fields hold their values.
  - Any acc in the same cycle is discarded.
  - Irq flags of discarded entries, plus in_irq that cycle, are OR'ed into irq_pend. An interrupt is never lost.
  - in_ready=1 the cycle after a flush.
- out_data is only meaningful when out_valid=1. When out_valid=0, field 0 equals NOP_VAL after reset or flush, so a downstream stage that ignores valid sees a NOP.
- Reset asserted mid-transfer: immediate return to reset values, with held words and irq_pend discarded. Deassertion is synchronised externally.
- Width rules: payload is NFIELDS*DATA_W bits with no arithmetic on it. cnt is 2 bits and never exceeds 2. Simulation asserts cnt<=2 and that in_valid & !in_ready leaves the stage unchanged.

Decomposition:
- Shared package: localparams for the cnt encodings (CNT_EMPTY, CNT_ONE, CNT_FULL) and a pipe_entry_t struct (data, irq, valid) parametrised through DATA_W*NFIELDS via package-level defaults.
- One natural sub-module: pipe_entry_reg, a single entry register with load, clear and bubble-on-clear behaviour. It is instantiated twice, for main and skid.

Test Plan:
1. Streaming: out_ready=1, 10 words in_data=32'h0000_0001..0A back-to-back -> each appears exactly 1 cycle later, in order, and in_ready stays 1 throughout.
2. Stall/skid: cnt=1 holding A, out_ready=0, push B -> cnt=2, in_ready=0 next cycle, out_data=A stable for 5 stall cycles. Then out_ready=1 -> A, B out on consecutive cycles and in_ready rises the cycle after A pops.
3. Sticky interrupt: out_ready=0, stage full, pulse in_irq for 1 cycle, then free the stage and push C -> C arrives with out_irq=1. The next word D arrives with out_irq=0.
4. Flush: cnt=2 (E, F) with in_valid=1 carrying G and flush=1 -> next cycle out_valid=0, field 0=8'h00, in_ready=1. E, F and G never appear at the output.
5. Flush with pending irq: E has irq=1 at flush -> the next accepted word H arrives with out_irq=1.
6. Async reset: assert rst mid-stall between clock edges -> outputs reach reset values before the next edge. After release, the first word passes with latency 1.

Source files
------------

// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the elastic pipeline stage: occupancy encodings and
// the default-width entry record.
package pipe_stage_skid_pkg;

  localparam int unsigned PKG_DATA_W  = 8;
  localparam int unsigned PKG_NFIELDS = 4;
  localparam int unsigned PKG_PAYLOAD_W = PKG_DATA_W * PKG_NFIELDS;

  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_ONE   = 2'd1;
  localparam logic [1:0] CNT_FULL  = 2'd2;

  typedef struct packed {
    logic [PKG_PAYLOAD_W-1:0] data;
    logic                     irq;
    logic                     valid;
  } pipe_entry_t;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Upstream/downstream handshake bundle for pipe_stage_skid; the stage takes the
// slave view, the surrounding pipeline drives it through the master view.
interface pipe_stage_skid_if #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NFIELDS = 4
);
  logic                        in_valid;
  logic                        in_ready;
  logic [NFIELDS*DATA_W-1:0]   in_data;
  logic                        in_irq;
  logic                        flush;
  logic                        out_valid;
  logic                        out_ready;
  logic [NFIELDS*DATA_W-1:0]   out_data;
  logic                        out_irq;

  modport slave (
    input  in_valid, in_data, in_irq, flush, out_ready,
    output in_ready, out_valid, out_data, out_irq
  );

  modport master (
    output in_valid, in_data, in_irq, flush, out_ready,
    input  in_ready, out_valid, out_data, out_irq
  );
endinterface

// File: rtl/pipe_stage_skid_entry_reg.sv
// One storage slot of the skid stage: payload, irq flag and valid bit, with a
// clear that leaves a NOP in field 0 so an unqualified reader sees a bubble.
module pipe_entry_reg #(
  parameter int unsigned      DATA_W  = 8,
  parameter int unsigned      NFIELDS = 4,
  parameter logic [DATA_W-1:0] NOP_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      drop,
  input  logic                      clear,
  input  logic [NFIELDS*DATA_W-1:0] d_data,
  input  logic                      d_irq,
  output logic [NFIELDS*DATA_W-1:0] q_data,
  output logic                      q_irq,
  output logic                      q_valid
);
  localparam int unsigned W = NFIELDS * DATA_W;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_data  <= W'(NOP_VAL);
      q_irq   <= 1'b0;
      q_valid <= 1'b0;
    end else if (clear) begin
      // Bubble: only the instruction slot is overwritten, other fields hold.
      q_data[DATA_W-1:0] <= NOP_VAL;
      q_irq              <= 1'b0;
      q_valid            <= 1'b0;
    end else if (load) begin
      q_data  <= d_data;
      q_irq   <= d_irq;
      q_valid <= 1'b1;
    end else if (drop) begin
      q_irq   <= 1'b0;
      q_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline register with a 2-entry skid buffer, flush-to-bubble and
// sticky interrupt capture; in_ready is decoded from registered occupancy only.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned       DATA_W  = 8,
  parameter int unsigned       NFIELDS = 4,
  parameter logic [DATA_W-1:0] NOP_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_stage_skid_if.slave     bus
);
  localparam int unsigned W = NFIELDS * DATA_W;

  logic [1:0]   cnt_q, cnt_d;
  logic         irq_pend_q, irq_pend_d;

  logic         acc, pop, irq_in;
  logic         main_load, main_from_skid, main_drop, main_clear;
  logic         skid_load, skid_drop, skid_clear;

  logic [W-1:0] main_data, skid_data, main_d_data;
  logic         main_irq, skid_irq, main_d_irq;
  logic         main_valid, skid_valid;

  assign bus.in_ready  = (cnt_q != CNT_FULL);
  assign bus.out_valid = main_valid;
  assign bus.out_data  = main_data;
  assign bus.out_irq   = main_irq;

  assign acc    = bus.in_valid & bus.in_ready;
  assign pop    = main_valid & bus.out_ready;
  assign irq_in = bus.in_irq | irq_pend_q;

  assign main_d_data = main_from_skid ? skid_data : bus.in_data;
  assign main_d_irq  = main_from_skid ? skid_irq  : irq_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= CNT_EMPTY;
      irq_pend_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    cnt_d          = cnt_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_drop      = 1'b0;
    main_clear     = 1'b0;
    skid_load      = 1'b0;
    skid_drop      = 1'b0;
    skid_clear     = 1'b0;
    irq_pend_d     = acc ? 1'b0 : (irq_pend_q | bus.in_irq);

    if (bus.flush) begin
      cnt_d      = CNT_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
      // A word popped this cycle was delivered with its flag, so only entries
      // that are actually thrown away fold their irq back into the pending bit.
      irq_pend_d = irq_pend_q | bus.in_irq
                 | (main_valid & main_irq & ~pop)
                 | (skid_valid & skid_irq);
    end else begin
      unique case (cnt_q)
        CNT_EMPTY: begin
          if (acc) begin
            main_load = 1'b1;
            cnt_d     = CNT_ONE;
          end
        end
        CNT_ONE: begin
          if (acc && pop) begin
            main_load = 1'b1;
          end else if (acc) begin
            skid_load = 1'b1;
            cnt_d     = CNT_FULL;
          end else if (pop) begin
            main_drop = 1'b1;
            cnt_d     = CNT_EMPTY;
          end
        end
        CNT_FULL: begin
          if (pop) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_drop      = 1'b1;
            cnt_d          = CNT_ONE;
          end
        end
        default: begin
          cnt_d      = CNT_EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  pipe_entry_reg #(.DATA_W(DATA_W), .NFIELDS(NFIELDS), .NOP_VAL(NOP_VAL)) u_main (
    .clk     (clk),
    .rst     (rst),
    .load    (main_load),
    .drop    (main_drop),
    .clear   (main_clear),
    .d_data  (main_d_data),
    .d_irq   (main_d_irq),
    .q_data  (main_data),
    .q_irq   (main_irq),
    .q_valid (main_valid)
  );

  pipe_entry_reg #(.DATA_W(DATA_W), .NFIELDS(NFIELDS), .NOP_VAL(NOP_VAL)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .drop    (skid_drop),
    .clear   (skid_clear),
    .d_data  (bus.in_data),
    .d_irq   (irq_in),
    .q_data  (skid_data),
    .q_irq   (skid_irq),
    .q_valid (skid_valid)
  );

  a_cnt_range : assert property (@(posedge clk) disable iff (rst) cnt_q <= CNT_FULL);

  a_refused_holds : assert property (@(posedge clk) disable iff (rst)
    (bus.in_valid && !bus.in_ready && !pop && !bus.flush)
      |=> ($stable(cnt_q) && $stable(main_data) && $stable(skid_data)));

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: streaming, skid stall, sticky irq,
// flush, flush with pending irq and asynchronous reset.
module tb_pipe_stage_skid;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  pipe_stage_skid_if #(.DATA_W(8), .NFIELDS(4)) bus ();

  pipe_stage_skid #(.DATA_W(8), .NFIELDS(4), .NOP_VAL(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_irq    = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_irq",   32'(bus.out_irq),   32'd0);
    check("rst_out_data",  bus.out_data,       32'h0000_0000);
    rst = 1'b0;

    // 1. Streaming, one word per cycle with latency 1
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'(i);
      tick();
      check("stream_valid", 32'(bus.out_valid), 32'd1);
      check("stream_data",  bus.out_data,       32'(i));
      check("stream_ready", 32'(bus.in_ready),  32'd1);
    end
    bus.in_valid = 1'b0;
    tick();
    check("stream_drain", 32'(bus.out_valid), 32'd0);

    // 2. Stall with skid; a refused word during the stall must never appear
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hA1A2_A3A4;
    tick();
    check("skid_a_data",  bus.out_data,      32'hA1A2_A3A4);
    check("skid_a_ready", 32'(bus.in_ready), 32'd1);
    bus.in_data = 32'hB1B2_B3B4;
    tick();
    check("skid_full_ready", 32'(bus.in_ready), 32'd0);
    bus.in_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_data",  bus.out_data,       32'hA1A2_A3A4);
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_ready", 32'(bus.in_ready),  32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("skid_b_data",  bus.out_data,      32'hB1B2_B3B4);
    check("skid_b_valid", 32'(bus.out_valid), 32'd1);
    check("skid_ready_up", 32'(bus.in_ready), 32'd1);
    tick();
    check("skid_drain", 32'(bus.out_valid), 32'd0);

    // 3. Sticky interrupt captured while full
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h0000_0011;
    tick();
    bus.in_data   = 32'h0000_0012;
    tick();
    bus.in_valid  = 1'b0;
    bus.in_irq    = 1'b1;
    tick();
    bus.in_irq    = 1'b0;
    check("irq_x1_flag", 32'(bus.out_irq), 32'd0);
    check("irq_x1_data", bus.out_data,     32'h0000_0011);
    bus.out_ready = 1'b1;
    tick();
    check("irq_x2_data", bus.out_data,     32'h0000_0012);
    check("irq_x2_flag", 32'(bus.out_irq), 32'd0);
    tick();
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0C0C_0C0C;
    tick();
    check("irq_c_data", bus.out_data,     32'h0C0C_0C0C);
    check("irq_c_flag", 32'(bus.out_irq), 32'd1);
    bus.in_data  = 32'h0D0D_0D0D;
    tick();
    check("irq_d_data", bus.out_data,     32'h0D0D_0D0D);
    check("irq_d_flag", 32'(bus.out_irq), 32'd0);
    bus.in_valid = 1'b0;
    tick();
    check("irq_drain", 32'(bus.out_valid), 32'd0);

    // 4. Flush while full, with a word offered in the same cycle
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hE1E2_E3E4;
    tick();
    bus.in_data   = 32'hF1F2_F3F4;
    tick();
    bus.in_data   = 32'h6162_6364;
    bus.flush     = 1'b1;
    tick();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    check("flush_valid", 32'(bus.out_valid), 32'd0);
    check("flush_data",  bus.out_data,       32'hE1E2_E300);
    check("flush_ready", 32'(bus.in_ready),  32'd1);
    check("flush_irq",   32'(bus.out_irq),   32'd0);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h0000_0055;
    tick();
    check("flush_h0_data", bus.out_data,     32'h0000_0055);
    check("flush_h0_irq",  32'(bus.out_irq), 32'd0);
    bus.in_valid  = 1'b0;
    tick();
    check("flush_drain", 32'(bus.out_valid), 32'd0);

    // 5. Flush discards a word carrying irq; the flag moves to the next word
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_irq    = 1'b1;
    bus.in_data   = 32'h0000_00E5;
    tick();
    check("firq_e_irq", 32'(bus.out_irq), 32'd1);
    bus.in_valid  = 1'b0;
    bus.in_irq    = 1'b0;
    bus.flush     = 1'b1;
    tick();
    bus.flush     = 1'b0;
    check("firq_valid", 32'(bus.out_valid), 32'd0);
    check("firq_irq",   32'(bus.out_irq),   32'd0);
    check("firq_data",  bus.out_data,       32'h0000_0000);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h1234_5648;
    tick();
    check("firq_h_data", bus.out_data,     32'h1234_5648);
    check("firq_h_irq",  32'(bus.out_irq), 32'd1);
    bus.in_valid  = 1'b0;
    tick();
    check("firq_drain", 32'(bus.out_valid), 32'd0);

    // 6. Asynchronous reset in the middle of a stall with an irq pending
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h0000_00A1;
    tick();
    bus.in_data   = 32'h0000_00A2;
    tick();
    bus.in_valid  = 1'b0;
    bus.in_irq    = 1'b1;
    tick();
    bus.in_irq    = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_ready", 32'(bus.in_ready),  32'd1);
    check("arst_data",  bus.out_data,       32'h0000_0000);
    check("arst_irq",   32'(bus.out_irq),   32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h0000_00C3;
    tick();
    check("arst_q_valid", 32'(bus.out_valid), 32'd1);
    check("arst_q_data",  bus.out_data,       32'h0000_00C3);
    check("arst_q_irq",   32'(bus.out_irq),   32'd0);
    bus.in_valid = 1'b0;
    tick();
    check("arst_drain", 32'(bus.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
